// File: rtl/add16_nibble_seq.sv
// Nibble-serial operand sequencer around an external 4-bit full adder.
// Operands go out LSB nibble first and the carry is chained through a register.
module add16_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    result;
  logic            carry_reg;
  logic [IW-1:0]   idx;
  logic            out_valid_q;
  logic            busy_q;

  // Each sum nibble enters at the top, so after NIBBLES shifts nibble 0 sits at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      result      <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= in_a;
            b_sh      <= in_b;
            carry_reg <= in_cin;
            idx       <= '0;
            result    <= '0;
            busy_q    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          result    <= (result >> 4) | (W'(add_sum) << (W - 4));
          carry_reg <= add_cout;
          a_sh      <= a_sh >> 4;
          b_sh      <= b_sh >> 4;
          idx       <= idx + 1'b1;
          if (idx == IW'(NIBBLES - 1)) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so the block never advertises ready while held in reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign add_a     = (state == RUN) ? a_sh[3:0] : 4'h0;
  assign add_b     = (state == RUN) ? b_sh[3:0] : 4'h0;
  assign add_cin   = (state == RUN) ? carry_reg : 1'b0;
  assign out_valid = out_valid_q;
  assign out_sum   = result;
  assign out_cout  = carry_reg;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add16_nibble_seq.sv
// Directed bench: a 16-bit and a single-nibble sequencer, each wrapped around a behavioural 4-bit adder.
module tb_add16_nibble_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_cin, add_cin, add_cout, out_valid, out_ready, out_cout, busy;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  add_a, add_b, add_sum;

  logic       in_valid1, in_ready1, in_cin1, add_cin1, add_cout1, out_valid1, out_ready1, out_cout1, busy1;
  logic [3:0] in_a1, in_b1, out_sum1, add_a1, add_b1, add_sum1;

  assign {add_cout, add_sum}   = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign {add_cout1, add_sum1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

  add16_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  add16_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Offers an operand pair for exactly one edge; returns in the first RUN cycle.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    checkOutput("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // cins: expected add_cin per nibble cycle, bit k for nibble k (hand-computed).
  task automatic runVector(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [3:0] cins, input logic [15:0] exp_sum, input logic exp_cout);
    applyStimulus(a, b, cin);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s.add_a[%0d]", tag, k), add_a, a[4*k +: 4]);
      checkOutput($sformatf("%s.add_b[%0d]", tag, k), add_b, b[4*k +: 4]);
      checkOutput($sformatf("%s.add_cin[%0d]", tag, k), add_cin, cins[k]);
      checkOutput($sformatf("%s.out_valid_run[%0d]", tag, k), out_valid, 0);
      checkOutput($sformatf("%s.busy_run[%0d]", tag, k), busy, 1);
      @(negedge clk);
    end
    checkOutput({tag, ".out_valid"}, out_valid, 1);
    checkOutput({tag, ".out_sum"}, out_sum, exp_sum);
    checkOutput({tag, ".out_cout"}, out_cout, exp_cout);
    checkOutput({tag, ".add_a_done"}, add_a, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".out_valid_after"}, out_valid, 0);
    checkOutput({tag, ".in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = '0; in_b1 = '0; in_cin1 = 0; out_ready1 = 0;
    #2;
    checkOutput("rst.in_ready_held", in_ready, 0);
    checkOutput("rst.out_valid_held", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst.in_ready", in_ready, 1);
    checkOutput("rst.out_valid", out_valid, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.add_a", add_a, 0);
    checkOutput("rst.add_b", add_b, 0);
    checkOutput("rst.add_cin", add_cin, 0);
    checkOutput("rst.out_sum", out_sum, 16'h0000);

    runVector("v1234", 16'h1234, 16'h0F0F, 1'b0, 4'b1010, 16'h2143, 1'b0);
    runVector("vffff1", 16'hFFFF, 16'h0001, 1'b0, 4'b1110, 16'h0000, 1'b1);
    runVector("vffffx2", 16'hFFFF, 16'hFFFF, 1'b1, 4'b1111, 16'hFFFF, 1'b1);

    // Backpressure: new operands offered the whole time must be ignored.
    applyStimulus(16'h1234, 16'h0F0F, 1'b0);
    in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("bp.out_valid[%0d]", c), out_valid, 1);
      checkOutput($sformatf("bp.out_sum[%0d]", c), out_sum, 16'h2143);
      checkOutput($sformatf("bp.out_cout[%0d]", c), out_cout, 0);
      checkOutput($sformatf("bp.in_ready[%0d]", c), in_ready, 0);
      in_a = in_a + 16'h0101;
      @(negedge clk);
    end
    in_a = 16'h0003; in_b = 16'h0004; in_cin = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp.out_valid_idle", out_valid, 0);
    checkOutput("bp.in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp.busy_accept", busy, 1);
    checkOutput("bp.add_a_new", add_a, 4'h3);
    checkOutput("bp.add_b_new", add_b, 4'h4);
    repeat (4) @(negedge clk);
    checkOutput("bp.out_valid_new", out_valid, 1);
    checkOutput("bp.out_sum_new", out_sum, 16'h0007);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Abort mid-RUN with an asynchronous reset.
    applyStimulus(16'h1234, 16'h0F0F, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort.in_ready", in_ready, 0);
    checkOutput("abort.out_valid", out_valid, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.add_a", add_a, 0);
    checkOutput("abort.add_b", add_b, 0);
    checkOutput("abort.add_cin", add_cin, 0);
    checkOutput("abort.out_sum", out_sum, 0);
    checkOutput("abort.out_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runVector("v0001", 16'h0001, 16'h0001, 1'b0, 4'b0000, 16'h0002, 1'b0);

    // Single-nibble instance: one RUN cycle then DONE.
    @(negedge clk);
    checkOutput("n1.in_ready", in_ready1, 1);
    in_a1 = 4'h9; in_b1 = 4'h8; in_cin1 = 1'b1; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    checkOutput("n1.add_a", add_a1, 4'h9);
    checkOutput("n1.add_b", add_b1, 4'h8);
    checkOutput("n1.add_cin", add_cin1, 1);
    checkOutput("n1.out_valid_run", out_valid1, 0);
    @(negedge clk);
    checkOutput("n1.out_valid", out_valid1, 1);
    checkOutput("n1.out_sum", out_sum1, 4'h2);
    checkOutput("n1.out_cout", out_cout1, 1);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    checkOutput("n1.out_valid_after", out_valid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
